// File: rtl/sqed_pkg.sv
// Shared constants for the SQED duplicate-instruction path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: instruction width, maximum duplicates per push, the NOP used
// as the idle instruction, and the width of the duplicate-count field.
package sqed_pkg;

    localparam int INSN_LEN  = 32;
    localparam int MAX_DUP   = 8;
    localparam int DUP_NUM_W = 4;

    // RISC-V "addi x0, x0, 0", presented to the core whenever nothing is queued.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage : sqed_pkg

// File: rtl/sepe_fifo_mem.sv
// Register array holding queued duplicate instructions, NPORT writes / 1 read.
// Latency: writes land on the next rising edge, read is combinational.
// Backpressure: none; the owner guarantees distinct addresses for enabled ports.
// Ports: clk; we/waddr/wdata per write port (packed, port 0 in the low slice);
//        raddr/rdata asynchronous read port. No reset on the contents.
module sepe_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int PTR_W = 4,
    parameter int NPORT = 8
) (
    input  logic                        clk,
    input  logic [NPORT-1:0]            we,
    input  logic [NPORT-1:0][PTR_W-1:0] waddr,
    input  logic [NPORT-1:0][WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]            raddr,
    output logic [WIDTH-1:0]            rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (we[p] && (waddr[p] == PTR_W'(e))) begin
                    mem[e] <= wdata[p];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule : sepe_fifo_mem

// File: rtl/sepe_dup_fifo.sv
// Multi-push / single-pop FIFO replaying SQED duplicate instructions to fetch.
// Latency: a pushed instruction is visible at out_insn one cycle after the push edge.
// Backpressure: in_ready drops when free space (registered count only) < clamped in_num.
// Ports: clk, rst_n (async, active low), flush (sync clear);
//        in_valid/in_ready/in_num/in_insn_0..7 push side (insn_0 oldest);
//        out_valid/out_ready/out_insn pop side (NOP when empty); count/full/empty status.
module sepe_dup_fifo #(
    parameter int INSN_LEN = sqed_pkg::INSN_LEN,
    parameter int DEPTH    = 16,
    parameter int MAX_DUP  = sqed_pkg::MAX_DUP,
    parameter int PTR_W    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [sqed_pkg::DUP_NUM_W-1:0] in_num,
    input  logic [INSN_LEN-1:0]            in_insn_0,
    input  logic [INSN_LEN-1:0]            in_insn_1,
    input  logic [INSN_LEN-1:0]            in_insn_2,
    input  logic [INSN_LEN-1:0]            in_insn_3,
    input  logic [INSN_LEN-1:0]            in_insn_4,
    input  logic [INSN_LEN-1:0]            in_insn_5,
    input  logic [INSN_LEN-1:0]            in_insn_6,
    input  logic [INSN_LEN-1:0]            in_insn_7,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [INSN_LEN-1:0]            out_insn,
    output logic [PTR_W:0]                 count,
    output logic                           full,
    output logic                           empty
);

    import sqed_pkg::*;

    localparam logic [PTR_W:0]         DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [DUP_NUM_W-1:0]   MAX_C   = DUP_NUM_W'(MAX_DUP);

    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [PTR_W:0]                 count_q;

    logic [DUP_NUM_W-1:0]           n_eff;
    logic [PTR_W:0]                 n_ext;
    logic [PTR_W:0]                 free_slots;
    logic                           push_fire;
    logic                           pop_fire;
    logic [PTR_W:0]                 push_add;
    logic [PTR_W:0]                 pop_sub;

    logic [MAX_DUP-1:0]             we;
    logic [MAX_DUP-1:0][PTR_W-1:0]  waddr;
    logic [MAX_DUP-1:0][INSN_LEN-1:0] wdata;
    logic [INSN_LEN-1:0]            head_dat;

    // Requests above MAX_DUP are treated as a full MAX_DUP burst.
    assign n_eff      = (in_num > MAX_C) ? MAX_C : in_num;
    assign n_ext      = (PTR_W+1)'(n_eff);
    assign free_slots = DEPTH_C - count_q;

    // Capacity comes from the registered count only, so a same-cycle pop
    // never opens room for a push (keeps in_ready off the out_ready path).
    assign in_ready  = (free_slots >= n_ext);
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign out_valid = !empty;
    assign count     = count_q;

    // n_eff == 0 completes the handshake but changes nothing.
    assign push_fire = in_valid && in_ready && (n_eff != '0);
    assign pop_fire  = out_valid && out_ready;
    assign push_add  = push_fire ? n_ext : '0;
    assign pop_sub   = pop_fire ? (PTR_W+1)'(1) : '0;

    assign wdata[0] = in_insn_0;
    assign wdata[1] = in_insn_1;
    assign wdata[2] = in_insn_2;
    assign wdata[3] = in_insn_3;
    assign wdata[4] = in_insn_4;
    assign wdata[5] = in_insn_5;
    assign wdata[6] = in_insn_6;
    assign wdata[7] = in_insn_7;

    // Port i writes slot wr_ptr+i; addresses wrap at PTR_W bits.
    always_comb begin
        we    = '0;
        waddr = '0;
        for (int i = 0; i < MAX_DUP; i++) begin
            we[i]    = push_fire && (DUP_NUM_W'(i) < n_eff);
            waddr[i] = wr_ptr + PTR_W'(i);
        end
    end

    sepe_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (INSN_LEN),
        .PTR_W (PTR_W),
        .NPORT (MAX_DUP)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (head_dat)
    );

    // Gated on empty so the un-reset array never leaks stale data.
    assign out_insn = empty ? INSN_LEN'(NOP_INST) : head_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(n_eff);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + push_add - pop_sub;
        end
    end

endmodule : sepe_dup_fifo

// File: tb/tb_sepe_dup_fifo.sv
module tb_sepe_dup_fifo;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_num;
    logic [31:0] insn [8];
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] A_B = 32'hA000_0000;
    localparam logic [31:0] B_B = 32'hB000_0000;
    localparam logic [31:0] C_B = 32'hC000_0000;
    localparam logic [31:0] E_B = 32'hE000_0000;
    localparam logic [31:0] F_B = 32'hF000_0000;
    localparam logic [31:0] D_B = 32'hD000_0000;
    localparam logic [31:0] G_B = 32'h6000_0000;
    localparam logic [31:0] H_B = 32'h7000_0000;
    localparam logic [31:0] J_B = 32'h9000_0000;

    sepe_dup_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_insn_0 (insn[0]),
        .in_insn_1 (insn[1]),
        .in_insn_2 (insn[2]),
        .in_insn_3 (insn[3]),
        .in_insn_4 (insn[4]),
        .in_insn_5 (insn[5]),
        .in_insn_6 (insn[6]),
        .in_insn_7 (insn[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_insn  (out_insn),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive push request; insn_k = base + k.
    task automatic set_push(input logic v, input logic [3:0] n, input logic [31:0] base);
        in_valid = v;
        in_num   = n;
        for (int k = 0; k < 8; k++) insn[k] = base + 32'(k);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_push(1'b0, 4'd0, 32'h0);
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic push_n(input logic [3:0] n, input logic [31:0] base);
        set_push(1'b1, n, base);
        step();
        idle();
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        in_num = 4'd8;
        repeat (2) @(posedge clk);
        #1;
        // 1. reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_insn", out_insn, NOP);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready8", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();
        chk("idle_count", 32'(count), 32'd0);

        // 2. single push, visible next cycle
        set_push(1'b1, 4'd1, 32'h00C5_8593);
        #1;
        chk("p1_in_ready", 32'(in_ready), 32'd1);
        chk("p1_no_writethru", out_insn, NOP);
        step();
        idle();
        chk("p1_out_valid", 32'(out_valid), 32'd1);
        chk("p1_out_insn", out_insn, 32'h00C5_8593);
        chk("p1_count", 32'(count), 32'd1);
        pop_one();
        chk("p1_drained", 32'(count), 32'd0);

        // 3. fill with two bursts of 8, reject third, drain in order
        push_n(4'd8, A_B);
        chk("fill_count8", 32'(count), 32'd8);
        push_n(4'd8, B_B);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count16", 32'(count), 32'd16);
        set_push(1'b1, 4'd1, 32'h1234_5678);
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step();
        idle();
        chk("full_count_hold", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_ab", out_insn, (i < 8) ? A_B + 32'(i) : B_B + 32'(i - 8));
            pop_one();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_nop", out_insn, NOP);
        pop_one();
        chk("pop_empty_count", 32'(count), 32'd0);

        // 4. capacity uses registered count only
        push_n(4'd8, C_B);
        push_n(4'd2, C_B + 32'd8);
        chk("c10_count", 32'(count), 32'd10);
        set_push(1'b1, 4'd8, 32'h5555_0000);
        out_ready = 1'b1;
        #1;
        chk("c10_in_ready", 32'(in_ready), 32'd0);
        step();
        idle();
        chk("c10_count9", 32'(count), 32'd9);
        pop_one();
        chk("c8_count", 32'(count), 32'd8);
        set_push(1'b1, 4'd8, E_B);
        out_ready = 1'b1;
        #1;
        chk("c8_in_ready", 32'(in_ready), 32'd1);
        step();
        idle();
        chk("c8_count15", 32'(count), 32'd15);
        for (int i = 0; i < 15; i++) begin
            chk("drain_ce", out_insn, (i < 7) ? C_B + 32'(3 + i) : E_B + 32'(i - 7));
            pop_one();
        end
        chk("ce_empty", 32'(empty), 32'd1);

        // 5. wrap: 12 in, 12 out, then 8 across the pointer wrap
        push_n(4'd8, F_B);
        push_n(4'd4, F_B + 32'd8);
        for (int i = 0; i < 12; i++) begin
            chk("drain_f", out_insn, F_B + 32'(i));
            pop_one();
        end
        push_n(4'd8, D_B);
        chk("wrap_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("drain_d", out_insn, D_B + 32'(i));
            pop_one();
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // 6. flush overrides push and pop; async reset clears immediately
        push_n(4'd5, G_B);
        chk("g_count5", 32'(count), 32'd5);
        set_push(1'b1, 4'd3, G_B + 32'd5);
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        idle();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        push_n(4'd4, G_B);
        chk("pre_arst_count", 32'(count), 32'd4);
        set_push(1'b1, 4'd3, G_B + 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_insn", out_insn, NOP);
        idle();
        step();
        rst_n = 1'b1;
        step();
        chk("post_arst_count", 32'(count), 32'd0);

        // 7. in_num above MAX_DUP clamps to 8
        push_n(4'd6, H_B);
        chk("h_count6", 32'(count), 32'd6);
        set_push(1'b1, 4'd12, J_B);
        #1;
        chk("clamp_in_ready", 32'(in_ready), 32'd1);
        step();
        idle();
        chk("clamp_count14", 32'(count), 32'd14);
        for (int i = 0; i < 14; i++) begin
            chk("drain_hj", out_insn, (i < 6) ? H_B + 32'(i) : J_B + 32'(i - 6));
            pop_one();
        end
        chk("clamp_empty", 32'(empty), 32'd1);

        // push with in_num=0 completes handshake without state change
        set_push(1'b1, 4'd0, J_B);
        #1;
        chk("num0_in_ready", 32'(in_ready), 32'd1);
        step();
        idle();
        chk("num0_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sepe_dup_fifo
